// File: rtl/gate_bist.sv
// gate_bist: exhaustive stimulus/response self-test for quad 2-input gate models.
module gate_bist #(
    parameter int WIDTH  = 4,
    parameter int SETTLE = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [1:0]           op,
    output logic [WIDTH-1:0]     dut_a,
    output logic [WIDTH-1:0]     dut_b,
    input  logic [WIDTH-1:0]     dut_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [2*WIDTH:0]     err_count,
    output logic                 fail_valid,
    output logic [WIDTH-1:0]     first_fail_a,
    output logic [WIDTH-1:0]     first_fail_b,
    output logic [WIDTH-1:0]     first_fail_y
);
    localparam int CW = $clog2(SETTLE + 1);

    typedef enum logic [2:0] {IDLE, DRIVE, WAIT, CHECK, FINISH} state_t;

    state_t               state, state_nx;
    logic [2*WIDTH-1:0]   vec;
    logic [1:0]           op_q;
    logic [CW-1:0]        cnt;
    logic [WIDTH-1:0]     exp_y;
    logic                 last;

    assign last  = &vec;
    assign exp_y = op_q == 2'b00 ? dut_a & dut_b :
                   op_q == 2'b01 ? dut_a | dut_b :
                   op_q == 2'b10 ? dut_a ^ dut_b : ~(dut_a & dut_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? DRIVE : IDLE;
            DRIVE:   state_nx = WAIT;
            WAIT:    state_nx = cnt == CW'(1) ? CHECK : WAIT;
            CHECK:   state_nx = last ? FINISH : DRIVE;
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy = state == DRIVE || state == WAIT || state == CHECK;
        done = state == FINISH;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec          <= '0;
            op_q         <= '0;
            cnt          <= '0;
            dut_a        <= '0;
            dut_b        <= '0;
            pass         <= 1'b0;
            err_count    <= '0;
            fail_valid   <= 1'b0;
            first_fail_a <= '0;
            first_fail_b <= '0;
            first_fail_y <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    op_q         <= op;
                    vec          <= '0;
                    pass         <= 1'b0;
                    err_count    <= '0;
                    fail_valid   <= 1'b0;
                    first_fail_a <= '0;
                    first_fail_b <= '0;
                    first_fail_y <= '0;
                end
                DRIVE: begin
                    {dut_a, dut_b} <= vec;
                    cnt            <= CW'(SETTLE);
                end
                WAIT: cnt <= cnt - 1'b1;
                CHECK: begin
                    if (dut_y != exp_y) begin
                        err_count <= err_count + 1'b1;
                        if (!fail_valid) begin
                            fail_valid   <= 1'b1;
                            first_fail_a <= dut_a;
                            first_fail_b <= dut_b;
                            first_fail_y <= dut_y;
                        end
                    end
                    if (!last) vec <= vec + 1'b1;
                end
                FINISH: begin
                    pass  <= err_count == '0;
                    dut_a <= '0;
                    dut_b <= '0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_gate_bist.sv
// tb_gate_bist: scoreboard bench for gate_bist with behavioural gate models as the DUT under test.
module tb_gate_bist;
    typedef struct {
        int         err;
        int         fv;
        int         fa;
        int         fb;
        int         fy;
        int         pass;
        int         done_at;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start0 = 1'b0, start1 = 1'b0;
    logic [1:0] op0 = 2'b00, op1 = 2'b00;
    logic [3:0] dut_a0, dut_b0, dut_y0, dut_a1, dut_b1, dut_y1;
    logic       busy0, done0, pass0, fail_valid0, busy1, done1, pass1, fail_valid1;
    logic [8:0] err_count0, err_count1;
    logic [3:0] ffa0, ffb0, ffy0, ffa1, ffb1, ffy1;
    int         mode0 = 0;
    int         cyc = 0;
    int         applied = 0;
    int         miscompares = 0;
    exp_t       sb0[$], sb1[$];
    exp_t       e0, e1;
    bit         pend0 = 0, pend1 = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // mode0: 0 = correct AND, 1 = AND with y[0] stuck at 0; instance 1 is a correct NAND
    assign dut_y0 = mode0 == 1 ? (dut_a0 & dut_b0 & 4'b1110) : (dut_a0 & dut_b0);
    assign dut_y1 = ~(dut_a1 & dut_b1);

    gate_bist u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .op(op0),
        .dut_a(dut_a0), .dut_b(dut_b0), .dut_y(dut_y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err_count0),
        .fail_valid(fail_valid0), .first_fail_a(ffa0), .first_fail_b(ffb0), .first_fail_y(ffy0)
    );

    gate_bist #(.WIDTH(4), .SETTLE(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .op(op1),
        .dut_a(dut_a1), .dut_b(dut_b1), .dut_y(dut_y1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
        .fail_valid(fail_valid1), .first_fail_a(ffa1), .first_fail_b(ffb1), .first_fail_y(ffy1)
    );

    task automatic cmp(input string name, input int act, input int req);
        applied++;
        if (act != req) begin
            miscompares++;
            $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
        end
    endtask

    function automatic exp_t mk(input int err, input int fv, input int fa, input int fb,
                                input int fy, input int pass);
        exp_t e;
        e.err = err; e.fv = fv; e.fa = fa; e.fb = fb; e.fy = fy; e.pass = pass; e.done_at = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (pend0) begin
            cmp("pass0", int'(pass0), e0.pass);
            pend0 = 0;
        end
        if (done0) begin
            if (sb0.size() == 0) begin
                applied++;
                miscompares++;
                $display("FAIL done0_unexpected: got done=1, required no pending run (cycle %0d)", cyc);
            end else begin
                e0 = sb0.pop_front();
                cmp("done_at0", cyc, e0.done_at);
                cmp("err_count0", int'(err_count0), e0.err);
                cmp("fail_valid0", int'(fail_valid0), e0.fv);
                cmp("first_fail_a0", int'(ffa0), e0.fa);
                cmp("first_fail_b0", int'(ffb0), e0.fb);
                cmp("first_fail_y0", int'(ffy0), e0.fy);
                cmp("busy_at_done0", int'(busy0), 0);
                pend0 = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (pend1) begin
            cmp("pass1", int'(pass1), e1.pass);
            pend1 = 0;
        end
        if (done1) begin
            if (sb1.size() == 0) begin
                applied++;
                miscompares++;
                $display("FAIL done1_unexpected: got done=1, required no pending run (cycle %0d)", cyc);
            end else begin
                e1 = sb1.pop_front();
                cmp("done_at1", cyc, e1.done_at);
                cmp("err_count1", int'(err_count1), e1.err);
                cmp("fail_valid1", int'(fail_valid1), e1.fv);
                pend1 = 1;
            end
        end
    end

    // Issues start on the next edge; expected done edge = start edge + 256*(SETTLE+2)
    task automatic run(input int sel, input logic [1:0] o, input exp_t e);
        @(negedge clk);
        e.done_at = cyc + 1 + (sel == 1 ? 768 : 1024);
        if (sel == 1) begin
            op1 = o; start1 = 1'b1; sb1.push_back(e);
        end else begin
            op0 = o; start0 = 1'b1; sb0.push_back(e);
        end
        @(negedge clk);
        start0 = 1'b0;
        start1 = 1'b0;
        cmp(sel == 1 ? "busy_after_start1" : "busy_after_start0", int'(sel == 1 ? busy1 : busy0), 1);
    endtask

    task automatic wait_idle(input int sel);
        int n = 0;
        while ((sel == 1 ? (sb1.size() != 0 || pend1) : (sb0.size() != 0 || pend0)) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000) begin
            applied++;
            miscompares++;
            $display("FAIL timeout%0d: got no done within 3000 cycles, required done", sel);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        cmp("rst_busy", int'(busy0), 0);
        cmp("rst_done", int'(done0), 0);
        cmp("rst_pass", int'(pass0), 0);
        cmp("rst_err", int'(err_count0), 0);
        cmp("rst_dut_a", int'(dut_a0), 0);
        cmp("rst_fail_valid", int'(fail_valid0), 0);
        rst_n = 1'b1;
        // correct AND, expected AND
        mode0 = 0;
        run(0, 2'b00, mk(0, 0, 0, 0, 0, 1));
        wait_idle(0);
        // y[0] stuck at 0: fails whenever a[0]&b[0]
        mode0 = 1;
        run(0, 2'b00, mk(64, 1, 1, 1, 0, 0));
        wait_idle(0);
        // AND model checked as XOR: only a=b=0 agrees
        mode0 = 0;
        run(0, 2'b10, mk(255, 1, 0, 1, 0, 0));
        wait_idle(0);
        // NAND model, SETTLE=1
        run(1, 2'b11, mk(0, 0, 0, 0, 0, 1));
        wait_idle(1);
        run(1, 2'b11, mk(0, 0, 0, 0, 0, 1));
        repeat (100) @(negedge clk);
        op1 = 2'b00;
        wait_idle(1);
        // start re-pulsed mid-run must be ignored
        run(0, 2'b00, mk(0, 0, 0, 0, 0, 1));
        repeat (9) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        repeat (489) @(negedge clk);
        start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        wait_idle(0);
        // reset mid-run with a faulty model so err_count is nonzero beforehand
        mode0 = 1;
        run(0, 2'b00, mk(64, 1, 1, 1, 0, 0));
        repeat (398) @(negedge clk);
        cmp("err_before_rst", int'(err_count0 != 0), 1);
        cmp("busy_before_rst", int'(busy0), 1);
        rst_n = 1'b0;
        #1;
        cmp("abort_busy", int'(busy0), 0);
        cmp("abort_done", int'(done0), 0);
        cmp("abort_pass", int'(pass0), 0);
        cmp("abort_err", int'(err_count0), 0);
        cmp("abort_fail_valid", int'(fail_valid0), 0);
        cmp("abort_dut_a", int'(dut_a0), 0);
        sb0.delete();
        @(negedge clk);
        rst_n = 1'b1;
        mode0 = 0;
        run(0, 2'b00, mk(0, 0, 0, 0, 0, 1));
        wait_idle(0);
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end
endmodule
